lcd_data_rearrange_buf: RTL and testbench

Page-data re-arrangement buffer that sits directly upstream of the LCD controller. It takes a request for one LCD page, identified as `{image, page}`, and reads that page's 64 row-major bytes from the picture ROM. It transposes them into 64 column bytes, each holding 8 vertical pixels, as the LCD page format requires. It then acknowledges and streams the column bytes at the controller's fixed two-clock byte cadence.

---
 rtl/lcd_data_rearrange_buf_if.sv | 21 ++
 rtl/lcd_data_rearrange_buf.sv | 121 ++++++++++++
 tb/tb_lcd_data_rearrange_buf.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_data_rearrange_buf_if.sv
// Handshake and ROM bus between the LCD controller, picture ROM and the page re-arrangement buffer.
// slave: the buffer itself; master: the controller/ROM side that drives requests and ROM data.
interface lcd_data_rearrange_buf_if;
    logic        data_request;
    logic [6:0]  addr;
    logic        data_ack;
    logic [7:0]  data;
    logic [12:0] rom_addr;
    logic        rom_rd;
    logic [7:0]  rom_data;

    modport slave (
        input  data_request, addr, rom_data,
        output data_ack, data, rom_addr, rom_rd
    );

    modport master (
        output data_request, addr, rom_data,
        input  data_ack, data, rom_addr, rom_rd
    );
endinterface

// File: rtl/lcd_data_rearrange_buf.sv
// Fetches one 64-byte LCD page from the picture ROM, transposes rows into column bytes, streams at 2 clk/byte.
// Define LCD_RDBUF_MIRROR_EN to store columns in reverse order (horizontally mirrored image).
module lcd_data_rearrange_buf (
    input  logic                        clk,
    input  logic                        rst_n,
    lcd_data_rearrange_buf_if.slave     bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;
    localparam logic [1:0] ST_STREAM = 2'd3;

    logic [1:0] state_q, state_d;
    logic [6:0] addr_q, addr_d;
    logic [6:0] j_q, j_d;
    logic [5:0] idx_q, idx_d;
    logic       phase_q, phase_d;
    logic       ack_q, ack_d;

    logic [7:0] col_q [64];

    // ROM data returning this cycle belongs to the read issued at j-1.
    logic       wr_en;
    logic [5:0] wr_idx;
    logic [2:0] wr_r, wr_b;

    assign wr_en  = (state_q == ST_FETCH) && (j_q != 7'd0);
    assign wr_idx = j_q[5:0] - 6'd1;
    assign wr_r   = wr_idx[5:3];
    assign wr_b   = wr_idx[2:0];

    assign bus.rom_rd   = (state_q == ST_FETCH) && !j_q[6];
    assign bus.rom_addr = bus.rom_rd ? {addr_q, j_q[5:0]} : 13'd0;
    assign bus.data     = col_q[idx_q];
    assign bus.data_ack = ack_q;

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        j_d     = j_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        ack_d   = ack_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.data_request) begin
                    addr_d  = bus.addr;
                    j_d     = 7'd0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!bus.data_request) begin
                    state_d = ST_IDLE;
                end else if (j_q == 7'd64) begin
                    j_d     = 7'd0;
                    ack_d   = 1'b1;
                    state_d = ST_READY;
                end else begin
                    j_d = j_q + 7'd1;
                end
            end
            ST_READY: begin
                if (!bus.data_request) begin
                    ack_d   = 1'b0;
                    idx_d   = 6'd0;
                    phase_d = 1'b0;
                    state_d = ST_STREAM;
                end
            end
            default: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (idx_q == 6'd63) begin
                        idx_d   = 6'd0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 7'd0;
            j_q     <= 7'd0;
            idx_q   <= 6'd0;
            phase_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            j_q     <= j_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            ack_q   <= ack_d;
        end
    end

    // NOTE: the column buffer is flops, not RAM, so it can and must be cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 64; c++) col_q[c] <= 8'h00;
        end else if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
`ifdef LCD_RDBUF_MIRROR_EN
                col_q[{~wr_b, 3'(i)}][wr_r] <= bus.rom_data[i];
`else
                col_q[{wr_b, 3'(7 - i)}][wr_r] <= bus.rom_data[i];
`endif
            end
        end
    end

endmodule

// File: tb/tb_lcd_data_rearrange_buf.sv
// Directed bench for lcd_data_rearrange_buf: page table, cadence, re-request, abort and reset corner cases.
// Honours LCD_RDBUF_MIRROR_EN so the expected columns follow the build's orientation.
module tb_lcd_data_rearrange_buf;

    typedef struct {
        int         pat;
        logic [6:0] addr;
        int         col_a;
        logic [7:0] val_a;
        int         col_b;
        logic [7:0] val_b;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   pat;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs [4];

    always #5 clk = ~clk;

    lcd_data_rearrange_buf_if bus ();

    lcd_data_rearrange_buf dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ROM contents: 0 = byte j holds j, 1 = checkerboard (odd rows AA, even rows 55),
    // 2 = row 0 blank, rest solid, 3 = single pixel at row 2 / byte 5 / leftmost bit.
    function automatic logic [7:0] rom_byte(int p, logic [5:0] j);
        case (p)
            0:       return {2'b00, j};
            1:       return j[3] ? 8'hAA : 8'h55;
            2:       return (j[5:3] == 3'd0) ? 8'h00 : 8'hFF;
            default: return (j == 6'd21) ? 8'h80 : 8'h00;
        endcase
    endfunction

    // Column c bit r = pixel at screen row r, x position c (x counted from the left, MSB first).
    function automatic logic [7:0] col_model(int p, int c);
        int         x;
        logic [7:0] v;
        logic [7:0] rb;
`ifdef LCD_RDBUF_MIRROR_EN
        x = 63 - c;
`else
        x = c;
`endif
        for (int r = 0; r < 8; r++) begin
            rb   = rom_byte(p, 6'(r * 8 + x / 8));
            v[r] = rb[7 - x % 8];
        end
        return v;
    endfunction

    always @(posedge clk) begin
        if (bus.rom_rd) bus.rom_data <= rom_byte(pat, bus.rom_addr[5:0]);
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_page(vec_t v, bit rereq);
        logic [7:0]  exp [64];
        logic [7:0]  got [64];
        logic [12:0] base;
        int          bad;
        pat  = v.pat;
        base = {v.addr, 6'd0};
        for (int c = 0; c < 64; c++) exp[c] = col_model(v.pat, c);
        bus.addr         = v.addr;
        bus.data_request = 1'b1;                      // cycle T
        bad = 0;
        for (int n = 0; n < 64; n++) begin
            tick();                                   // T+1+n
            if (bus.rom_rd !== 1'b1 || bus.rom_addr !== base + 13'(n)) bad++;
        end
        check("fetch_addr_seq", bad, 0);
        tick();                                       // T+65
        check("fetch_done_no_ack", {bus.rom_rd, bus.data_ack}, 0);
        tick();                                       // T+66
        check("ack_rise", bus.data_ack, 1);
        tick();
        tick();
        check("ack_hold", bus.data_ack, 1);
        bus.data_request = 1'b0;                      // cycle S
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            for (int h = 0; h < 2; h++) begin
                tick();                               // S+1+2k+h
                if (rereq && k == 0 && h == 0) bus.data_request = 1'b1;
                if (bus.data !== exp[k] || bus.data_ack !== 1'b0) bad++;
                got[k] = bus.data;
            end
        end
        check("stream_cadence", bad, 0);
        check("col_a", got[v.col_a], v.val_a);
        check("col_b", got[v.col_b], v.val_b);
        tick();                                       // S+129: back in IDLE
        check("stream_end_idle", {bus.rom_rd, bus.data_ack}, 0);
        if (rereq) begin
            tick();                                   // S+130: request latched at S+129
            check("rereq_fetch_start", {bus.rom_rd, bus.rom_addr}, {1'b1, base});
            bus.data_request = 1'b0;
            tick();
            check("rereq_abort", bus.rom_rd, 0);
        end
    endtask

    initial begin
`ifdef LCD_RDBUF_MIRROR_EN
        vecs[0] = '{0, 7'h0B, 0, 8'hFF, 63, 8'h00};
        vecs[1] = '{1, 7'h2A, 0, 8'h55, 1, 8'hAA};
        vecs[2] = '{2, 7'h7F, 0, 8'hFE, 37, 8'hFE};
        vecs[3] = '{3, 7'h00, 23, 8'h04, 40, 8'h00};
`else
        vecs[0] = '{0, 7'h0B, 0, 8'h00, 63, 8'hFF};
        vecs[1] = '{1, 7'h2A, 0, 8'hAA, 1, 8'h55};
        vecs[2] = '{2, 7'h7F, 0, 8'hFE, 37, 8'hFE};
        vecs[3] = '{3, 7'h00, 40, 8'h04, 23, 8'h00};
`endif
        rst_n            = 1'b0;
        bus.data_request = 1'b0;
        bus.addr         = 7'd0;
        pat              = 0;
        #1;
        check("reset_outputs", {bus.data_ack, bus.rom_rd, bus.data, bus.rom_addr}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            check("idle_quiet", {bus.data_ack, bus.rom_rd, bus.data}, 0);
        end

        for (int n = 0; n < 4; n++) run_page(vecs[n], 1'b0);

        // Request held high across STREAM is ignored until the IDLE cycle after it.
        run_page(vecs[1], 1'b1);

        // Abort at j=20, then a fresh full fetch.
        pat              = 0;
        bus.addr         = 7'h15;
        bus.data_request = 1'b1;
        for (int n = 0; n <= 20; n++) tick();
        check("abort_j20_addr", bus.rom_addr, {7'h15, 6'd20});
        bus.data_request = 1'b0;
        tick();
        check("abort_idle", {bus.rom_rd, bus.data_ack}, 0);
        for (int n = 0; n < 5; n++) begin
            tick();
            check("abort_no_ack", bus.data_ack, 0);
        end
        run_page(vecs[0], 1'b0);

        // Reset while READY drops ack asynchronously.
        pat              = 1;
        bus.addr         = 7'h2A;
        bus.data_request = 1'b1;
        for (int n = 0; n < 66; n++) tick();
        check("ready_ack_before_rst", bus.data_ack, 1);
        rst_n = 1'b0;
        #1;
        check("rst_ready_ack", bus.data_ack, 0);
        bus.data_request = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Reset mid-STREAM at idx=30.
        bus.data_request = 1'b1;
        for (int n = 0; n < 66; n++) tick();
        bus.data_request = 1'b0;                      // cycle S
        for (int n = 0; n < 61; n++) tick();          // S+61: idx 30, phase 0
        check("stream_idx30", bus.data, col_model(1, 30));
        rst_n = 1'b0;
        #1;
        check("rst_stream_outputs", {bus.data_ack, bus.rom_rd, bus.data}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_page(vecs[2], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
